// File: rtl/alu_op_sequencer_if.sv
// Bus interface for alu_op_sequencer.
// Groups the upstream instruction handshake, the registered ALU drive / ALU result return,
// and the downstream result handshake.
//   slave  : the sequencer side (consumes instr/operands and alu_result, drives the rest)
//   master : the environment side (upstream stage, ALU and downstream stage)
// Optional feature: ALU_SEQ_ZERO_FLAG_EN adds the zero flag signal.
interface alu_op_sequencer_if #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned FUNCT_WIDTH = 6
);
  logic [31:0]            instr;
  logic [DATA_WIDTH-1:0]  rs_data;
  logic [DATA_WIDTH-1:0]  rt_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_WIDTH-1:0]  alu_op1;
  logic [DATA_WIDTH-1:0]  alu_op2;
  logic [FUNCT_WIDTH-1:0] alu_funct;
  logic [DATA_WIDTH-1:0]  alu_result;
  logic [DATA_WIDTH-1:0]  result;
  logic                   out_valid;
  logic                   out_ready;
  logic                   err;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic                   zero;

  modport slave (
    input  instr, rs_data, rt_data, in_valid, alu_result, out_ready,
    output in_ready, alu_op1, alu_op2, alu_funct, result, out_valid, err, zero
  );
  modport master (
    output instr, rs_data, rt_data, in_valid, alu_result, out_ready,
    input  in_ready, alu_op1, alu_op2, alu_funct, result, out_valid, err, zero
  );
`else
  modport slave (
    input  instr, rs_data, rt_data, in_valid, alu_result, out_ready,
    output in_ready, alu_op1, alu_op2, alu_funct, result, out_valid, err
  );
  modport master (
    output instr, rs_data, rt_data, in_valid, alu_result, out_ready,
    input  in_ready, alu_op1, alu_op2, alu_funct, result, out_valid, err
  );
`endif
endinterface

// File: rtl/alu_op_sequencer.sv
// Execute-stage ALU sequencer.
// Accepts a MiniMIPS instruction plus rs/rt values, decodes them into registered ALU
// operands and function code, captures the combinational ALU result one cycle later and
// offers it downstream. Unsupported instructions complete with err=1 and result=0.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset
//   bus   : alu_op_sequencer_if.slave (instr/rs_data/rt_data/in_valid/in_ready,
//           alu_op1/alu_op2/alu_funct/alu_result, result/out_valid/out_ready/err[/zero])
// Optional feature: ALU_SEQ_ZERO_FLAG_EN adds the registered zero flag.
module alu_op_sequencer #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned FUNCT_WIDTH = 6
) (
  input logic               clk_i,
  input logic               rst_i,
  alu_op_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  op1_q, op1_d;
  logic [DATA_WIDTH-1:0]  op2_q, op2_d;
  logic [FUNCT_WIDTH-1:0] funct_q, funct_d;
  logic [DATA_WIDTH-1:0]  result_q, result_d;
  logic                   out_valid_q, out_valid_d;
  logic                   err_q, err_d;
  logic                   zero_q, zero_d;

  // Decode
  logic [5:0]             opcode, funct;
  logic [4:0]             shamt;
  logic [15:0]            imm;
  logic [DATA_WIDTH-1:0]  imm_se, imm_ze, shamt_ze;
  logic                   dec_ok;
  logic [DATA_WIDTH-1:0]  dec_op1, dec_op2;
  logic [FUNCT_WIDTH-1:0] dec_funct;
  logic                   unused_instr;

  assign opcode       = bus.instr[31:26];
  assign shamt        = bus.instr[10:6];
  assign funct        = bus.instr[5:0];
  assign imm          = bus.instr[15:0];
  assign imm_se       = {{(DATA_WIDTH-16){imm[15]}}, imm};
  assign imm_ze       = {{(DATA_WIDTH-16){1'b0}}, imm};
  assign shamt_ze     = {{(DATA_WIDTH-5){1'b0}}, shamt};
  // Register specifiers are resolved upstream by the register file read.
  assign unused_instr = ^bus.instr[25:16];

  always_comb begin
    dec_ok    = 1'b1;
    dec_funct = FUNCT_WIDTH'(funct);
    dec_op1   = bus.rs_data;
    dec_op2   = bus.rt_data;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20, 6'h22, 6'h2c, 6'h24, 6'h25, 6'h27, 6'h2a: ;
          6'h01, 6'h02: dec_op2 = shamt_ze;
          default:      dec_ok  = 1'b0;
        endcase
      end
      6'h08: begin dec_funct = FUNCT_WIDTH'(6'h20); dec_op2 = imm_se; end
      6'h1d: begin dec_funct = FUNCT_WIDTH'(6'h2c); dec_op2 = imm_se; end
      6'h0a: begin dec_funct = FUNCT_WIDTH'(6'h2a); dec_op2 = imm_se; end
      6'h0c: begin dec_funct = FUNCT_WIDTH'(6'h24); dec_op2 = imm_ze; end
      6'h0d: begin dec_funct = FUNCT_WIDTH'(6'h25); dec_op2 = imm_ze; end
      // lui is an sll of the zero-extended immediate by 16.
      6'h0f: begin
        dec_funct = FUNCT_WIDTH'(6'h01);
        dec_op1   = imm_ze;
        dec_op2   = DATA_WIDTH'(16);
      end
      default: dec_ok = 1'b0;
    endcase
  end

  // Next state
  always_comb begin
    state_d     = state_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    funct_d     = funct_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;
    zero_d      = zero_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          if (dec_ok) begin
            op1_d   = dec_op1;
            op2_d   = dec_op2;
            funct_d = dec_funct;
            state_d = StExec;
          end else begin
            // ALU drive is left untouched on an unsupported instruction.
            result_d    = '0;
            err_d       = 1'b1;
            zero_d      = 1'b0;
            out_valid_d = 1'b1;
            state_d     = StDone;
          end
        end
      end
      StExec: begin
        result_d    = bus.alu_result;
        err_d       = 1'b0;
        zero_d      = (bus.alu_result == '0);
        out_valid_d = 1'b1;
        state_d     = StDone;
      end
      StDone: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      op1_q       <= '0;
      op2_q       <= '0;
      funct_q     <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      funct_q     <= funct_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      zero_q      <= zero_d;
    end
  end

  // Not ready while reset is asserted even though the state already reads idle.
  assign bus.in_ready  = (state_q == StIdle) && !rst_i;
  assign bus.alu_op1   = op1_q;
  assign bus.alu_op2   = op2_q;
  assign bus.alu_funct = funct_q;
  assign bus.result    = result_q;
  assign bus.out_valid = out_valid_q;
  assign bus.err       = err_q;

`ifdef ALU_SEQ_ZERO_FLAG_EN
  assign bus.zero = zero_q;
`else
  logic unused_zero;
  assign unused_zero = zero_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: directed cases, randomized instructions against an
// instruction-level reference model, backpressure, back-to-back streaming and mid-op reset.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_op_sequencer_if #(.DATA_WIDTH(32), .FUNCT_WIDTH(6)) bus ();

  alu_op_sequencer #(.DATA_WIDTH(32), .FUNCT_WIDTH(6)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Combinational ALU
  always_comb begin
    bus.alu_result = 'x;
    case (bus.alu_funct)
      6'h20: bus.alu_result = bus.alu_op1 + bus.alu_op2;
      6'h22: bus.alu_result = bus.alu_op1 - bus.alu_op2;
      6'h2c: bus.alu_result = bus.alu_op1 * bus.alu_op2;
      6'h01: bus.alu_result = bus.alu_op1 << bus.alu_op2[4:0];
      6'h02: bus.alu_result = bus.alu_op1 >> bus.alu_op2[4:0];
      6'h24: bus.alu_result = bus.alu_op1 & bus.alu_op2;
      6'h25: bus.alu_result = bus.alu_op1 | bus.alu_op2;
      6'h27: bus.alu_result = ~(bus.alu_op1 | bus.alu_op2);
      6'h2a: bus.alu_result = ($signed(bus.alu_op1) < $signed(bus.alu_op2)) ? 32'd1 : 32'd0;
      default: ;
    endcase
  end

  typedef struct packed {
    logic        err;
    logic [5:0]  funct;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] result;
  } exp_t;

  // Instruction-level semantics: what the instruction computes, and what the ALU must see.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs,
                                 input logic [31:0] rt);
    exp_t        e;
    logic [31:0] se, ze, sh;
    se = {{16{ins[15]}}, ins[15:0]};
    ze = {16'h0, ins[15:0]};
    sh = {27'h0, ins[10:6]};
    e  = '0;
    e.op1 = rs;
    case (ins[31:26])
      6'h00: begin
        e.funct = ins[5:0];
        e.op2   = rt;
        case (ins[5:0])
          6'h20: e.result = rs + rt;
          6'h22: e.result = rs - rt;
          6'h2c: e.result = rs * rt;
          6'h01: begin e.op2 = sh; e.result = rs << ins[10:6]; end
          6'h02: begin e.op2 = sh; e.result = rs >> ins[10:6]; end
          6'h24: e.result = rs & rt;
          6'h25: e.result = rs | rt;
          6'h27: e.result = ~(rs | rt);
          6'h2a: e.result = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0;
          default: e.err = 1'b1;
        endcase
      end
      6'h08: begin e.funct = 6'h20; e.op2 = se; e.result = rs + se; end
      6'h1d: begin e.funct = 6'h2c; e.op2 = se; e.result = rs * se; end
      6'h0a: begin
        e.funct = 6'h2a; e.op2 = se;
        e.result = ($signed(rs) < $signed(se)) ? 32'd1 : 32'd0;
      end
      6'h0c: begin e.funct = 6'h24; e.op2 = ze; e.result = rs & ze; end
      6'h0d: begin e.funct = 6'h25; e.op2 = ze; e.result = rs | ze; end
      6'h0f: begin
        e.funct = 6'h01; e.op1 = ze; e.op2 = 32'd16; e.result = {ins[15:0], 16'h0};
      end
      default: e.err = 1'b1;
    endcase
    if (e.err) e.result = '0;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [5:0]  fl [9];
    int          k;
    fl = '{6'h20, 6'h22, 6'h2c, 6'h01, 6'h02, 6'h24, 6'h25, 6'h27, 6'h2a};
    w  = $urandom;
    k  = $urandom_range(0, 17);
    if (k < 9) begin
      w[31:26] = 6'h00; w[5:0] = fl[k];
    end else begin
      case (k)
        9:  w[31:26] = 6'h08;
        10: w[31:26] = 6'h1d;
        11: w[31:26] = 6'h0a;
        12: w[31:26] = 6'h0c;
        13: w[31:26] = 6'h0d;
        14: w[31:26] = 6'h0f;
        15: begin w[31:26] = 6'h00; w[5:0] = 6'h03; end
        16: w[31:26] = 6'h3f;
        default: w[31:26] = 6'h23;
      endcase
    end
    return w;
  endfunction

  // Drives one instruction and observes its completion; no checking here.
  task automatic send(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                      input int hold, output int lat, output logic [31:0] res,
                      output logic err, output logic [31:0] o1, output logic [31:0] o2,
                      output logic [5:0] f, output logic z, output bit held_ok,
                      output bit post_ok, output bit timeout);
    int n;
    timeout = 1'b0;
    @(negedge clk);
    bus.instr    = ins;
    bus.rs_data  = rs;
    bus.rt_data  = rt;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 10) begin @(negedge clk); n++; end
    if (!bus.in_ready) timeout = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 8) begin @(posedge clk); #1; lat++; end
    if (!bus.out_valid) timeout = 1'b1;
    res = bus.result;
    err = bus.err;
    o1  = bus.alu_op1;
    o2  = bus.alu_op2;
    f   = bus.alu_funct;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    z = bus.zero;
`else
    z = 1'b0;
`endif
    held_ok = 1'b1;
    repeat (hold) begin
      @(posedge clk); #1;
      if (bus.result !== res || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.err !== err) held_ok = 1'b0;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    post_ok = (bus.out_valid === 1'b0) && (bus.in_ready === 1'b1);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.err !== 1'b0 ||
        bus.result !== 32'h0 || bus.alu_op1 !== 32'h0 || bus.alu_op2 !== 32'h0 ||
        bus.alu_funct !== 6'h0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b vld=%b err=%b res=%h op1=%h op2=%h f=%h, want all 0",
               bus.in_ready, bus.out_valid, bus.err, bus.result, bus.alu_op1, bus.alu_op2,
               bus.alu_funct);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ins [4];
    logic [31:0] rsv [4];
    logic [31:0] res, o1, o2, p1, p2;
    logic [5:0]  f, pf;
    logic        e, z;
    int          lat;
    bit          h, p, t;
    exp_t        x;
    ins = '{32'h2022FFFF, 32'h00000102, 32'h3C011234, 32'hFC000000};
    rsv = '{32'd5, 32'h80, 32'h0, 32'h1234_5678};
    for (int i = 0; i < 4; i++) begin
      p1 = bus.alu_op1; p2 = bus.alu_op2; pf = bus.alu_funct;
      x = model(ins[i], rsv[i], 32'h0);
      send(ins[i], rsv[i], 32'h0, 0, lat, res, e, o1, o2, f, z, h, p, t);
      if (x.err) begin x.op1 = p1; x.op2 = p2; x.funct = pf; end
      checks++;
      if (t || lat != (x.err ? 1 : 2) || res !== x.result || e !== x.err || o1 !== x.op1 ||
          o2 !== x.op2 || f !== x.funct || !p) begin
        errors++;
        $display("FAIL directed_%0d: lat=%0d res=%h err=%b op1=%h op2=%h f=%h post=%b to=%b, want lat=%0d res=%h err=%b op1=%h op2=%h f=%h",
                 i, lat, res, e, o1, o2, f, p, t, x.err ? 1 : 2, x.result, x.err, x.op1,
                 x.op2, x.funct);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] res, o1, o2;
    logic [5:0]  f;
    logic        e, z;
    int          lat;
    bit          h, p, t;
    send(32'h2022FFFF, 32'd5, 32'd0, 5, lat, res, e, o1, o2, f, z, h, p, t);
    checks++;
    if (t || res !== 32'd4 || !h || !p) begin
      errors++;
      $display("FAIL backpressure: res=%h held=%b post=%b to=%b, want res=4 held=1 post=1",
               res, h, p, t);
    end
  endtask

  task automatic test_random();
    logic [31:0] ins, rs, rt, res, o1, o2, p1, p2;
    logic [5:0]  f, pf;
    logic        e, z;
    int          lat;
    bit          h, p, t;
    exp_t        x;
    for (int i = 0; i < 40; i++) begin
      ins = rand_instr();
      rs  = $urandom;
      rt  = ($urandom_range(0, 3) == 0) ? rs : $urandom;
      p1 = bus.alu_op1; p2 = bus.alu_op2; pf = bus.alu_funct;
      x = model(ins, rs, rt);
      if (x.err) begin x.op1 = p1; x.op2 = p2; x.funct = pf; end
      send(ins, rs, rt, $urandom_range(0, 3), lat, res, e, o1, o2, f, z, h, p, t);
      checks++;
      if (t || lat != (x.err ? 1 : 2) || res !== x.result || e !== x.err || o1 !== x.op1 ||
          o2 !== x.op2 || f !== x.funct || !h || !p) begin
        errors++;
        $display("FAIL random_%0d ins=%h: lat=%0d res=%h err=%b op1=%h op2=%h f=%h held=%b post=%b, want lat=%0d res=%h err=%b op1=%h op2=%h f=%h",
                 i, ins, lat, res, e, o1, o2, f, h, p, x.err ? 1 : 2, x.result, x.err,
                 x.op1, x.op2, x.funct);
      end
`ifdef ALU_SEQ_ZERO_FLAG_EN
      checks++;
      if (z !== (!x.err && x.result == 32'h0)) begin
        errors++;
        $display("FAIL random_zero_%0d: got %b want %b", i, z, !x.err && x.result == 32'h0);
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    exp_t q[$];
    exp_t x;
    int   acc_n, ohs_n;
    bit   acc, ohs;
    acc_n = 0; ohs_n = 0;
    @(negedge clk);
    do begin
      bus.instr = rand_instr(); bus.rs_data = $urandom; bus.rt_data = $urandom;
    end while (model(bus.instr, bus.rs_data, bus.rt_data).err);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      acc = bus.in_valid && bus.in_ready;
      ohs = bus.out_valid && bus.out_ready;
      if (ohs) begin
        ohs_n++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL b2b_unexpected_output: res=%h", bus.result);
        end else begin
          x = q.pop_front();
          if (bus.result !== x.result || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_result: got %h err=%b want %h err=0", bus.result, bus.err,
                     x.result);
          end
        end
      end
      @(posedge clk);
      if (acc) begin
        acc_n++;
        q.push_back(model(bus.instr, bus.rs_data, bus.rt_data));
        #1;
        do begin
          bus.instr = rand_instr(); bus.rs_data = $urandom; bus.rt_data = $urandom;
        end while (model(bus.instr, bus.rs_data, bus.rt_data).err);
      end
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checks++;
    if (acc_n != 10 || ohs_n != 10 || q.size() != 0) begin
      errors++;
      $display("FAIL b2b_throughput: accepts=%0d outputs=%0d pending=%0d, want 10 10 0",
               acc_n, ohs_n, q.size());
    end
  endtask

  task automatic test_reset_mid_exec();
    logic [31:0] res, o1, o2;
    logic [5:0]  f;
    logic        e, z;
    int          lat;
    bit          h, p, t, stray;
    @(negedge clk);
    bus.instr = 32'h2022FFFF; bus.rs_data = 32'd9; bus.rt_data = 32'd0; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.result !== 32'h0 || bus.err !== 1'b0 ||
        bus.alu_op1 !== 32'h0 || bus.alu_op2 !== 32'h0 || bus.alu_funct !== 6'h0 ||
        bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_exec: vld=%b res=%h err=%b op1=%h op2=%h f=%h rdy=%b, want 0s",
               bus.out_valid, bus.result, bus.err, bus.alu_op1, bus.alu_op2, bus.alu_funct,
               bus.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    stray = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_exec_ready: got %b want 1", bus.in_ready);
    end
    repeat (3) begin @(posedge clk); #1; if (bus.out_valid !== 1'b0) stray = 1'b1; end
    checks++;
    if (stray) begin
      errors++;
      $display("FAIL reset_mid_exec_no_output: out_valid rose after aborted op");
    end
    // sub 7-7
    send(32'h00000022, 32'd7, 32'd7, 0, lat, res, e, o1, o2, f, z, h, p, t);
    checks++;
    if (t || res !== 32'h0 || e !== 1'b0 || !p) begin
      errors++;
      $display("FAIL sub_after_reset: res=%h err=%b post=%b, want 0 0 1", res, e, p);
    end
`ifdef ALU_SEQ_ZERO_FLAG_EN
    checks++;
    if (z !== 1'b1) begin
      errors++;
      $display("FAIL zero_flag_sub: got %b want 1", z);
    end
`endif
  endtask

  initial begin
    bus.instr     = '0;
    bus.rs_data   = '0;
    bus.rt_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_reset_mid_exec();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
